// File: rtl/cache_snoop_ctrl_pkg.sv
// Shared MESI, snoop-bus and snoop-FSM encodings for the cache snoop path.
package cache_rtl_def;

  typedef enum logic [2:0] {
    MESI_INVALID   = 3'd0,
    MESI_SHARED    = 3'd1,
    MESI_EXCLUSIVE = 3'd2,
    MESI_MODIFIED  = 3'd3
  } mesi_t;

  typedef enum logic [1:0] {
    BUS_NO_REQ     = 2'd0,
    BUS_READ       = 2'd1,
    BUS_INVALIDATE = 2'd2,
    BUS_RWITM      = 2'd3
  } bus_req_t;

  typedef enum logic [1:0] {
    BUS_NO_RSP          = 2'd0,
    BUS_SNOOP_FOUND_RSP = 2'd1
  } bus_rsp_t;

  typedef enum logic [2:0] {
    SNP_IDLE = 3'd0,
    SNP_ARB  = 3'd1,
    SNP_RD   = 3'd2,
    SNP_CHK  = 3'd3,
    SNP_WB   = 3'd4,
    SNP_UPD  = 3'd5,
    SNP_RSP  = 3'd6
  } snoop_state_t;

endpackage

// File: rtl/fsm_bus_req_ctrl.sv
// Combinational MESI transition for a snooped bus request against a resident line:
// next state, whether dirty data must be written back, and the bus response.
module fsm_bus_req_ctrl
  import cache_rtl_def::*;
(
  input  logic [2:0] state,
  input  logic [1:0] bus_req,
  output logic [2:0] nxt_state,
  output logic       write_back,
  output logic [1:0] send_bus_rsp
);

  always_comb begin
    nxt_state    = state;
    write_back   = 1'b0;
    send_bus_rsp = BUS_NO_RSP;
    if (mesi_t'(state) != MESI_INVALID) begin
      case (bus_req_t'(bus_req))
        BUS_READ: begin
          nxt_state    = MESI_SHARED;
          write_back   = (mesi_t'(state) == MESI_MODIFIED);
          send_bus_rsp = BUS_SNOOP_FOUND_RSP;
        end
        // The requester is about to overwrite the line, so dirty data is dropped.
        BUS_INVALIDATE: begin
          nxt_state = MESI_INVALID;
        end
        BUS_RWITM: begin
          nxt_state    = MESI_INVALID;
          write_back   = (mesi_t'(state) == MESI_MODIFIED);
          send_bus_rsp = BUS_SNOOP_FOUND_RSP;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cache_snoop_ctrl.sv
// Serialises snoop requests through lookup, optional write-back and state update of
// the shared tag/state array; the array stays locked from arbitration to response.
module cache_snoop_ctrl
  import cache_rtl_def::*;
#(
  parameter int  ADDR_W = 32,
  parameter int  IDX_W  = 6,
  parameter int  OFF_W  = 4,
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_req_vld,
  output logic              bus_req_rdy,
  input  logic [1:0]        bus_req,
  input  logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rsp_vld,
  output logic [1:0]        bus_rsp,
  output logic              arr_req,
  input  logic              arr_gnt,
  output logic              arr_rd_en,
  output logic [IDX_W-1:0]  arr_idx,
  input  logic [TAG_W-1:0]  arr_rd_tag,
  input  logic [2:0]        arr_rd_state,
  output logic              arr_wr_en,
  output logic [2:0]        arr_wr_state,
  output logic              wb_req_vld,
  input  logic              wb_req_rdy,
  output logic [IDX_W-1:0]  wb_idx,
  output logic [TAG_W-1:0]  wb_tag,
  output logic              busy
);

  snoop_state_t     state, nxt;
  logic [1:0]       req_q;
  logic [IDX_W-1:0] idx_q;
  logic [TAG_W-1:0] tag_q;
  logic             hit_q;
  logic [2:0]       nst_q;
  logic [1:0]       rsp_q;

  logic             hit;
  logic             accept;
  logic [2:0]       sm_nxt;
  logic             sm_wb;
  logic [1:0]       sm_rsp;
  logic             unused_off;

  assign unused_off = ^bus_addr[OFF_W-1:0];

  fsm_bus_req_ctrl u_bus_req_ctrl (
    .state        (arr_rd_state),
    .bus_req      (req_q),
    .nxt_state    (sm_nxt),
    .write_back   (sm_wb),
    .send_bus_rsp (sm_rsp)
  );

  assign hit    = (arr_rd_tag == tag_q) && (mesi_t'(arr_rd_state) != MESI_INVALID);
  assign accept = (state == SNP_IDLE) && bus_req_vld && (bus_req_t'(bus_req) != BUS_NO_REQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SNP_IDLE;
      req_q <= '0;
      idx_q <= '0;
      tag_q <= '0;
      hit_q <= 1'b0;
      nst_q <= '0;
      rsp_q <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        req_q <= bus_req;
        idx_q <= bus_addr[OFF_W +: IDX_W];
        tag_q <= bus_addr[ADDR_W-1 -: TAG_W];
      end
      if (state == SNP_CHK) begin
        hit_q <= hit;
        nst_q <= sm_nxt;
        rsp_q <= sm_rsp;
      end
    end
  end

  always_comb begin
    nxt         = state;
    bus_req_rdy = 1'b0;
    bus_rsp_vld = 1'b0;
    bus_rsp     = BUS_NO_RSP;
    arr_req     = 1'b0;
    arr_rd_en   = 1'b0;
    arr_wr_en   = 1'b0;
    wb_req_vld  = 1'b0;
    case (state)
      SNP_IDLE: begin
        bus_req_rdy = 1'b1;
        if (accept) nxt = SNP_ARB;
      end
      SNP_ARB: begin
        arr_req = 1'b1;
        if (arr_gnt) nxt = SNP_RD;
      end
      SNP_RD: begin
        arr_req   = 1'b1;
        arr_rd_en = 1'b1;
        nxt       = SNP_CHK;
      end
      SNP_CHK: begin
        arr_req = 1'b1;
        if (!hit)       nxt = SNP_RSP;
        else if (sm_wb) nxt = SNP_WB;
        else            nxt = SNP_UPD;
      end
      SNP_WB: begin
        arr_req    = 1'b1;
        wb_req_vld = 1'b1;
        if (wb_req_rdy) nxt = SNP_UPD;
      end
      SNP_UPD: begin
        arr_req   = 1'b1;
        arr_wr_en = 1'b1;
        nxt       = SNP_RSP;
      end
      SNP_RSP: begin
        arr_req     = 1'b1;
        bus_rsp_vld = 1'b1;
        bus_rsp     = hit_q ? rsp_q : BUS_NO_RSP;
        nxt         = SNP_IDLE;
      end
      default: nxt = SNP_IDLE;
    endcase
  end

  assign arr_idx      = idx_q;
  assign arr_wr_state = nst_q;
  assign wb_idx       = idx_q;
  assign wb_tag       = tag_q;
  assign busy         = (state != SNP_IDLE);

endmodule

// File: tb/tb_cache_snoop_ctrl.sv
// Directed bench for cache_snoop_ctrl with a behavioural tag/state array.
module tb_cache_snoop_ctrl;

  localparam int ADDR_W = 32;
  localparam int IDX_W  = 6;
  localparam int OFF_W  = 4;
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

  localparam logic [2:0] ST_I = 3'd0, ST_S = 3'd1, ST_E = 3'd2, ST_M = 3'd3;
  localparam logic [1:0] RQ_READ = 2'd1, RQ_INV = 2'd2, RQ_RWITM = 2'd3;
  localparam logic [1:0] RS_NONE = 2'd0, RS_FOUND = 2'd1;

  logic              clk = 1'b0;
  logic              rst;
  logic              bus_req_vld;
  logic              bus_req_rdy;
  logic [1:0]        bus_req;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_rsp_vld;
  logic [1:0]        bus_rsp;
  logic              arr_req;
  logic              arr_gnt;
  logic              arr_rd_en;
  logic [IDX_W-1:0]  arr_idx;
  logic [TAG_W-1:0]  arr_rd_tag;
  logic [2:0]        arr_rd_state;
  logic              arr_wr_en;
  logic [2:0]        arr_wr_state;
  logic              wb_req_vld;
  logic              wb_req_rdy;
  logic [IDX_W-1:0]  wb_idx;
  logic [TAG_W-1:0]  wb_tag;
  logic              busy;

  always #5 clk = ~clk;

  cache_snoop_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .bus_req_vld  (bus_req_vld),
    .bus_req_rdy  (bus_req_rdy),
    .bus_req      (bus_req),
    .bus_addr     (bus_addr),
    .bus_rsp_vld  (bus_rsp_vld),
    .bus_rsp      (bus_rsp),
    .arr_req      (arr_req),
    .arr_gnt      (arr_gnt),
    .arr_rd_en    (arr_rd_en),
    .arr_idx      (arr_idx),
    .arr_rd_tag   (arr_rd_tag),
    .arr_rd_state (arr_rd_state),
    .arr_wr_en    (arr_wr_en),
    .arr_wr_state (arr_wr_state),
    .wb_req_vld   (wb_req_vld),
    .wb_req_rdy   (wb_req_rdy),
    .wb_idx       (wb_idx),
    .wb_tag       (wb_tag),
    .busy         (busy)
  );

  // Array model: one-cycle read latency; ld_* preloads lines from the bench.
  logic [TAG_W-1:0] mem_tag [64];
  logic [2:0]       mem_st  [64];
  logic             ld_en = 1'b0;
  logic [IDX_W-1:0] ld_idx;
  logic [TAG_W-1:0] ld_tag;
  logic [2:0]       ld_st;

  always @(posedge clk) begin
    if (ld_en) begin
      mem_tag[ld_idx] <= ld_tag;
      mem_st[ld_idx]  <= ld_st;
    end else if (arr_wr_en) begin
      mem_st[arr_idx] <= arr_wr_state;
    end
    if (arr_rd_en) begin
      arr_rd_tag   <= mem_tag[arr_idx];
      arr_rd_state <= mem_st[arr_idx];
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic preload(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tg,
                         input logic [2:0] st);
    ld_en = 1'b1; ld_idx = idx; ld_tag = tg; ld_st = st;
    @(posedge clk);
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Results of the most recent snoop; cycle k=1 is the cycle after acceptance.
  int               lat;
  logic [1:0]       rsp_seen;
  int               wr_cnt;
  logic [2:0]       wr_st_seen;
  int               wb_cnt;
  logic [IDX_W-1:0] wb_idx_seen;
  logic [TAG_W-1:0] wb_tag_seen;
  bit               wb_stable;
  bit               req_held;
  bit               rdy_low;
  bit               early_rd;
  logic             post_req;
  logic             post_rdy;

  task automatic snoop(input logic [1:0] req, input logic [31:0] addr, input int stall,
                       input int gnt_low, input bit keep_vld);
    int  left;
    bit  gnt_given;
    lat = -1; rsp_seen = 2'bx; wr_cnt = 0; wr_st_seen = 3'bx; wb_cnt = 0;
    wb_stable = 1'b1; req_held = 1'b1; rdy_low = 1'b1; early_rd = 1'b0;
    left = stall;
    gnt_given = (gnt_low == 0);
    arr_gnt = gnt_given;
    bus_req_vld = 1'b1; bus_req = req; bus_addr = addr;
    for (int i = 0; i < 20 && !bus_req_rdy; i++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    if (!keep_vld) bus_req_vld = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (!arr_req) req_held = 1'b0;
      if (bus_req_rdy) rdy_low = 1'b0;
      if (arr_rd_en && !gnt_given) early_rd = 1'b1;
      if (arr_wr_en) begin wr_cnt++; wr_st_seen = arr_wr_state; end
      wb_req_rdy = 1'b0;
      if (wb_req_vld) begin
        if (wb_cnt == 0) begin
          wb_idx_seen = wb_idx; wb_tag_seen = wb_tag;
        end else if (wb_idx !== wb_idx_seen || wb_tag !== wb_tag_seen) begin
          wb_stable = 1'b0;
        end
        wb_cnt++;
        if (left > 0) left--;
        else wb_req_rdy = 1'b1;
      end
      if (bus_rsp_vld) begin
        lat = k; rsp_seen = bus_rsp;
        break;
      end
      if (k > gnt_low) begin arr_gnt = 1'b1; gnt_given = 1'b1; end
      @(negedge clk);
    end
    wb_req_rdy = 1'b0;
    @(negedge clk);
    post_req = arr_req;
    post_rdy = bus_req_rdy;
  endtask

  initial begin
    rst = 1'b1; bus_req_vld = 1'b0; bus_req = 2'd0; bus_addr = '0;
    arr_gnt = 1'b1; wb_req_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_rdy",   32'(bus_req_rdy), 1);
    check("rst_busy",  32'(busy), 0);
    check("rst_arreq", 32'(arr_req), 0);
    check("rst_rspv",  32'(bus_rsp_vld), 0);
    check("rst_rsp",   32'(bus_rsp), 32'(RS_NONE));
    check("rst_wbv",   32'(wb_req_vld), 0);

    preload(6'h23, 22'd4, ST_M);
    preload(6'h05, 22'd9, ST_E);
    preload(6'h3F, 22'h2AF379, ST_M);

    // READ on Modified with a 3-cycle write-back stall.
    snoop(RQ_READ, 32'h0000_1230, 3, 0, 1'b0);
    check("m_rd_wbcnt",  32'(wb_cnt), 4);
    check("m_rd_wbidx",  32'(wb_idx_seen), 32'h23);
    check("m_rd_wbtag",  32'(wb_tag_seen), 4);
    check("m_rd_wbstab", 32'(wb_stable), 1);
    check("m_rd_wrcnt",  32'(wr_cnt), 1);
    check("m_rd_wrst",   32'(wr_st_seen), 32'(ST_S));
    check("m_rd_rsp",    32'(rsp_seen), 32'(RS_FOUND));
    check("m_rd_lat",    32'(lat), 9);
    check("m_rd_memst",  32'(mem_st[6'h23]), 32'(ST_S));
    check("m_rd_relreq", 32'(post_req), 0);

    snoop(RQ_RWITM, 32'h0000_2450, 0, 0, 1'b0);
    check("e_rwitm_wb",   32'(wb_cnt), 0);
    check("e_rwitm_wrst", 32'(wr_st_seen), 32'(ST_I));
    check("e_rwitm_rsp",  32'(rsp_seen), 32'(RS_FOUND));
    check("e_rwitm_lat",  32'(lat), 5);

    snoop(RQ_INV, 32'hABCD_E7F0, 0, 0, 1'b0);
    check("m_inv_wb",   32'(wb_cnt), 0);
    check("m_inv_wrc",  32'(wr_cnt), 1);
    check("m_inv_wrst", 32'(wr_st_seen), 32'(ST_I));
    check("m_inv_rsp",  32'(rsp_seen), 32'(RS_NONE));
    check("m_inv_lat",  32'(lat), 5);

    // Same set as 0x1230 but a different tag.
    snoop(RQ_READ, 32'h0000_1630, 0, 0, 1'b0);
    check("miss_tag_wr",  32'(wr_cnt), 0);
    check("miss_tag_rsp", 32'(rsp_seen), 32'(RS_NONE));
    check("miss_tag_lat", 32'(lat), 4);

    // Tag matches but the line was invalidated by the RWITM above.
    snoop(RQ_READ, 32'h0000_2450, 0, 0, 1'b0);
    check("miss_inv_wr",  32'(wr_cnt), 0);
    check("miss_inv_rsp", 32'(rsp_seen), 32'(RS_NONE));
    check("miss_inv_lat", 32'(lat), 4);

    // Grant withheld 10 cycles while a second request waits at the port.
    snoop(RQ_READ, 32'h0000_1230, 0, 10, 1'b1);
    check("gnt_req_held", 32'(req_held), 1);
    check("gnt_no_early", 32'(early_rd), 0);
    check("gnt_rdy_low",  32'(rdy_low), 1);
    check("gnt_lat",      32'(lat), 15);
    check("gnt_rsp",      32'(rsp_seen), 32'(RS_FOUND));
    check("gnt_post_rdy", 32'(post_rdy), 1);
    snoop(RQ_RWITM, 32'h0000_1230, 0, 0, 1'b0);
    check("b2b_lat",  32'(lat), 5);
    check("b2b_wrst", 32'(wr_st_seen), 32'(ST_I));

    // Reset in the middle of a write-back stall.
    preload(6'h01, 22'd2, ST_M);
    arr_gnt = 1'b1; wb_req_rdy = 1'b0;
    bus_req_vld = 1'b1; bus_req = RQ_READ; bus_addr = 32'h0000_0810;
    @(posedge clk);
    @(negedge clk);
    bus_req_vld = 1'b0;
    for (int i = 0; i < 20 && !wb_req_vld; i++) @(negedge clk);
    check("rst_wb_seen", 32'(wb_req_vld), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rmid_arreq", 32'(arr_req), 0);
    check("rmid_wbv",   32'(wb_req_vld), 0);
    check("rmid_rspv",  32'(bus_rsp_vld), 0);
    check("rmid_wren",  32'(arr_wr_en), 0);
    check("rmid_rden",  32'(arr_rd_en), 0);
    check("rmid_busy",  32'(busy), 0);
    check("rmid_rdy",   32'(bus_req_rdy), 1);
    check("rmid_wbidx", 32'(wb_idx), 0);
    @(negedge clk);
    check("rmid_rspv2", 32'(bus_rsp_vld), 0);
    check("rmid_memst", 32'(mem_st[6'h01]), 32'(ST_M));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
